// File: rtl/lh_msg_if.sv
// Byte-stream handshake bundle between the message source, the feeder and the hash core.
// Signals: in_valid/in_ready/in_char/in_last (upstream), core_ready/m_valid/ptxt_char/m_last (downstream).
interface lh_msg_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       in_last;
    logic       core_ready;
    logic       m_valid;
    logic [7:0] ptxt_char;
    logic       m_last;

    modport slave (
        input  in_valid, in_char, in_last, core_ready,
        output in_ready, m_valid, ptxt_char, m_last
    );

    modport master (
        output in_valid, in_char, in_last, core_ready,
        input  in_ready, m_valid, ptxt_char, m_last
    );
endinterface

// File: rtl/lh_msg_feeder.sv
// Light-hash message feeder: FIFO-buffers an input byte stream, emits it one byte per
// cycle and appends 0x80, zero fill and a length byte so the total is a multiple of
// BLOCK_BYTES. Flags non-letter bytes on err_invalid_char.
// Ports: clk, rst_n (async active-low), bus (lh_msg_if.slave: input and output
// handshakes), busy (message in flight), err_invalid_char (pulse per non-letter byte).
// Optional macro LH_FEED_FILTER_EN: drop non-letter bytes instead of passing them.
module lh_msg_feeder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BLOCK_BYTES = 8,
    parameter int LEN_W       = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    lh_msg_if.slave bus,
    output logic    busy,
    output logic    err_invalid_char
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(BLOCK_BYTES);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PRE_LEN  = PW'(BLOCK_BYTES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAD_MARK,
        S_PAD_ZERO,
        S_PAD_LEN
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ready_en_q;
    logic            last_pend_q, last_pend_d;
    logic            m_valid_q, m_valid_d;
    logic [7:0]      ptxt_q, ptxt_d;
    logic            m_last_q, m_last_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic            err_q, err_d;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            is_letter;
    logic            keep_in;
    logic            advance;
    logic            taken;
    logic [PW-1:0]   load_pos;
    logic [9:0]      head;

    assign is_letter = (bus.in_char >= 8'h41 && bus.in_char <= 8'h5A) ||
                       (bus.in_char >= 8'h61 && bus.in_char <= 8'h7A);

`ifdef LH_FEED_FILTER_EN
    assign keep_in = is_letter;
`else
    assign keep_in = 1'b1;
`endif

    // in_ready depends on registered state only, never on core_ready
    assign bus.in_ready = ready_en_q && (cnt_q != FULL_CNT) && !last_pend_q;
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_empty   = (cnt_q == '0);
    assign head         = mem_q[rd_ptr_q];

    assign advance  = !m_valid_q || bus.core_ready;
    assign taken    = m_valid_q && bus.core_ready;
    // Position of the byte loaded this cycle: the held byte (if any) is leaving
    assign load_pos = pos_q + {{(PW-1){1'b0}}, m_valid_q};

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        ptxt_d    = ptxt_q;
        m_last_d  = m_last_q;
        len_d     = len_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_DATA;
            end
            S_DATA: begin
                if (advance) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head[8]) begin
                            m_valid_d = 1'b1;
                            ptxt_d    = head[7:0];
                            len_d     = len_q + LEN_W'(1);
                        end
                        if (head[9]) state_d = S_PAD_MARK;
                    end
                end
            end
            S_PAD_MARK: begin
                if (advance) begin
                    m_valid_d = 1'b1;
                    ptxt_d    = 8'h80;
                    m_last_d  = 1'b0;
                    state_d   = (load_pos == PRE_LEN) ? S_PAD_LEN : S_PAD_ZERO;
                end
            end
            S_PAD_ZERO: begin
                if (advance) begin
                    m_valid_d = 1'b1;
                    ptxt_d    = 8'h00;
                    m_last_d  = 1'b0;
                    if (load_pos == PRE_LEN) state_d = S_PAD_LEN;
                end
            end
            S_PAD_LEN: begin
                // First load the length byte, then wait for it to be taken
                if (m_last_q) begin
                    if (bus.core_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        len_d     = '0;
                        state_d   = S_IDLE;
                    end
                end else if (advance) begin
                    m_valid_d = 1'b1;
                    ptxt_d    = len_q[7:0];
                    m_last_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        last_pend_d = last_pend_q;
        if (push && bus.in_last) last_pend_d = 1'b1;
        if (taken && m_last_q) last_pend_d = 1'b0;
        pos_d = pos_q;
        if (taken) pos_d = pos_q + PW'(1);
        if (taken && m_last_q) pos_d = '0;
        err_d = push && !is_letter;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_last, keep_in, bus.in_char};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ready_en_q  <= 1'b0;
            last_pend_q <= 1'b0;
            m_valid_q   <= 1'b0;
            ptxt_q      <= 8'h00;
            m_last_q    <= 1'b0;
            pos_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= 1'b1;
            last_pend_q <= last_pend_d;
            m_valid_q   <= m_valid_d;
            ptxt_q      <= ptxt_d;
            m_last_q    <= m_last_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    assign bus.m_valid      = m_valid_q;
    assign bus.ptxt_char    = ptxt_q;
    assign bus.m_last       = m_last_q;
    assign err_invalid_char = err_q;
    assign busy             = (state_q != S_IDLE) || !fifo_empty || m_valid_q;
endmodule
